// File: rtl/ova_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ova_pkg
// Description : Shared definitions for the OV DVP capture front end.
//               - framing FSM state encoding
//               - bytes-per-pixel legality check
//               - default line length and counter width
// Revision    : 1.0 - initial release
// ============================================================================
package ova_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,   // waiting for a vsync pulse to begin
        S_VS   = 2'd1,   // inside vsync, decide capture at its trailing edge
        S_ACT  = 2'd2    // frame active, lines being captured
    } ova_state_t;

    localparam int c_PIX_BYTES_MIN = 1;
    localparam int c_PIX_BYTES_MAX = 2;
    localparam int c_LINE_PIX_DEF  = 640;
    localparam int c_CNT_W_DEF     = 12;

    function automatic bit pix_bytes_legal(input int pb);
        return (pb >= c_PIX_BYTES_MIN) && (pb <= c_PIX_BYTES_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ova_pix_pack.sv
`default_nettype none
// ============================================================================
// Module      : ova_pix_pack
// Description : Byte phase counter and pixel assembler. Takes the registered
//               sensor byte stream and produces one pixel word per
//               PIX_BYTES href-high bytes.
// Ports       : i_pclk, rst_n      clock, async active-low reset
//               clr_i              clear byte phase (frame start)
//               href_i             registered line valid
//               href_rise_i        first href-high byte of a line
//               data_i[7:0]        registered sensor byte
//               pix_o[15:0]        assembled pixel (valid with done_o)
//               done_o             pixel completes on this byte
//               phase_nz_o         a partial pixel is pending
// Revision    : 1.0 - initial release
// ============================================================================
module ova_pix_pack #(
    parameter int PIX_BYTES = 2,
    parameter int BYTE_SWAP = 0
) (
    input  logic        i_pclk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        href_i,
    input  logic        href_rise_i,
    input  logic [7:0]  data_i,
    output logic [15:0] pix_o,
    output logic        done_o,
    output logic        phase_nz_o
);

    localparam logic c_PH_LAST = (PIX_BYTES == 2);

    logic phase_q;
    logic w_phase_cur;

    // The first byte of a line always starts a new pixel, whatever the
    // phase register was left at by a previous truncated line.
    assign w_phase_cur = href_rise_i ? 1'b0 : phase_q;
    assign done_o      = href_i && (w_phase_cur == c_PH_LAST);
    assign phase_nz_o  = phase_q;

    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else if (clr_i) begin
            phase_q <= 1'b0;
        end else if (href_i) begin
            phase_q <= ~done_o;
        end
    end

    if (PIX_BYTES == 1) begin : g_pb1
        assign pix_o = {8'h00, data_i};
    end else begin : g_pb2
        logic [7:0] byte0_q;

        always_ff @(posedge i_pclk or negedge rst_n) begin
            if (!rst_n) begin
                byte0_q <= 8'h00;
            end else if (href_i && !done_o) begin
                byte0_q <= data_i;
            end
        end

        if (BYTE_SWAP != 0) begin : g_swap
            assign pix_o = {data_i, byte0_q};
        end else begin : g_noswap
            assign pix_o = {byte0_q, data_i};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ova_capture.sv
`default_nettype none
// ============================================================================
// Module      : ova_capture
// Description : Frame-aware DVP capture front end. Tracks vsync/href framing,
//               packs 1 or 2 bytes per pixel, crops to a window latched at
//               frame start, emits sof/eol/eof markers, ping-pong buffer
//               select, frame counter and a sticky malformed-line flag.
// Ports       : i_pclk, rst_n             clock, async active-low reset
//               i_data, href, vsync       sensor pins
//               i_cap_en                  capture enable (sampled at frame start)
//               i_x0/i_x1/i_y0/i_y1       inclusive crop window
//               o_data, o_data_vld        pixel output
//               o_sof, o_eol, o_eof       frame / line markers
//               o_buf_sel                 ping-pong line buffer select
//               o_frame_act               frame capture in progress
//               o_line_err                sticky malformed-line flag
//               o_frame_cnt               completed frame count
// Revision    : 1.0 - initial release
// ============================================================================
module ova_capture
    import ova_pkg::*;
#(
    parameter int PIX_BYTES = 2,
    parameter int BYTE_SWAP = 0,
    parameter int LINE_PIX  = c_LINE_PIX_DEF,
    parameter int VSYNC_POL = 1,
    parameter int CNT_W     = c_CNT_W_DEF
) (
    input  logic             i_pclk,
    input  logic             rst_n,
    input  logic [7:0]       i_data,
    input  logic             href,
    input  logic             vsync,
    input  logic             i_cap_en,
    input  logic [CNT_W-1:0] i_x0,
    input  logic [CNT_W-1:0] i_x1,
    input  logic [CNT_W-1:0] i_y0,
    input  logic [CNT_W-1:0] i_y1,
    output logic [15:0]      o_data,
    output logic             o_data_vld,
    output logic             o_sof,
    output logic             o_eol,
    output logic             o_eof,
    output logic             o_buf_sel,
    output logic             o_frame_act,
    output logic             o_line_err,
    output logic [15:0]      o_frame_cnt
);

    if (!pix_bytes_legal(PIX_BYTES)) begin : g_bad_pix_bytes
        $error("ova_capture: PIX_BYTES must be 1 or 2");
    end

    localparam logic             c_VS_INV   = (VSYNC_POL == 0);
    localparam logic [CNT_W-1:0] c_LINE_PIX = CNT_W'(LINE_PIX);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    // ---------------------------------------------------------------- stage 1
    logic [7:0] data_q;
    logic       href_q, href_p_q;
    logic       vs_q, vs_p_q;

    // vs history resets to "active" so a vsync already high when reset is
    // released is not mistaken for a rising edge: capture needs a full pulse.
    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= 8'h00;
            href_q   <= 1'b0;
            href_p_q <= 1'b0;
            vs_q     <= 1'b1;
            vs_p_q   <= 1'b1;
        end else begin
            data_q   <= i_data;
            href_q   <= href;
            href_p_q <= href_q;
            vs_q     <= vsync ^ c_VS_INV;
            vs_p_q   <= vs_q;
        end
    end

    logic w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;
    assign w_vs_rise   =  vs_q   & ~vs_p_q;
    assign w_vs_fall   = ~vs_q   &  vs_p_q;
    assign w_href_rise =  href_q & ~href_p_q;
    assign w_href_fall = ~href_q &  href_p_q;

    // ------------------------------------------------------------ FSM state
    ova_state_t       state_q;
    logic [CNT_W-1:0] x_q, y_q;
    logic [CNT_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic             sof_pend_q;
    logic [15:0]      data_out_q;
    logic             vld_q, sof_q, eol_q, eof_q;
    logic             buf_sel_q, frame_act_q, line_err_q;
    logic [15:0]      frame_cnt_q;

    logic w_act_entry;
    assign w_act_entry = (state_q == S_VS) && w_vs_fall && i_cap_en;

    // --------------------------------------------------------------- packer
    logic [15:0] w_pix;
    logic        w_pix_done;
    logic        w_phase_nz;

    ova_pix_pack #(
        .PIX_BYTES (PIX_BYTES),
        .BYTE_SWAP (BYTE_SWAP)
    ) u_pack (
        .i_pclk      (i_pclk),
        .rst_n       (rst_n),
        .clr_i       (w_act_entry),
        .href_i      (href_q),
        .href_rise_i (w_href_rise),
        .data_i      (data_q),
        .pix_o       (w_pix),
        .done_o      (w_pix_done),
        .phase_nz_o  (w_phase_nz)
    );

    // ----------------------------------------------------- window compare
    logic             w_x_in, w_y_in;
    logic [CNT_W-1:0] w_x_inc, w_y_inc;

    assign w_x_in  = (x_q >= x0_q) && (x_q <= x1_q);
    assign w_y_in  = (y_q >= y0_q) && (y_q <= y1_q);
    // Saturating increments: an index stuck at all-ones stays there.
    assign w_x_inc = (&x_q) ? x_q : x_q + c_ONE;
    assign w_y_inc = (&y_q) ? y_q : y_q + c_ONE;

    // ------------------------------------------ framing FSM and outputs
    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            x_q         <= '0;
            y_q         <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            sof_pend_q  <= 1'b0;
            data_out_q  <= 16'h0000;
            vld_q       <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            buf_sel_q   <= 1'b0;
            frame_act_q <= 1'b0;
            line_err_q  <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            vld_q <= 1'b0;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
            eof_q <= 1'b0;

            case (state_q)
                S_WAIT: begin
                    if (w_vs_rise) begin
                        state_q <= S_VS;
                    end
                end

                S_VS: begin
                    if (w_vs_fall) begin
                        if (i_cap_en) begin
                            state_q     <= S_ACT;
                            x0_q        <= i_x0;
                            x1_q        <= i_x1;
                            y0_q        <= i_y0;
                            y1_q        <= i_y1;
                            x_q         <= '0;
                            y_q         <= '0;
                            line_err_q  <= 1'b0;
                            sof_pend_q  <= 1'b1;
                            frame_act_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end

                S_ACT: begin
                    if (w_vs_rise) begin
                        state_q     <= S_VS;
                        eof_q       <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        frame_act_q <= 1'b0;
                        // A pixel landing on the frame end is dropped so
                        // eof never shares a cycle with valid data.
                        if (w_pix_done) begin
                            line_err_q <= 1'b1;
                        end
                    end else begin
                        // pix_done needs href high, line end needs it low,
                        // so the two branches never fire together.
                        if (w_pix_done) begin
                            if (w_x_in && w_y_in) begin
                                data_out_q <= w_pix;
                                vld_q      <= 1'b1;
                                sof_q      <= sof_pend_q;
                                eol_q      <= (x_q == x1_q);
                                sof_pend_q <= 1'b0;
                            end
                            x_q <= w_x_inc;
                        end
                        if (w_href_fall) begin
                            if ((x_q != c_LINE_PIX) || w_phase_nz) begin
                                line_err_q <= 1'b1;
                            end
                            if (w_y_in) begin
                                buf_sel_q <= ~buf_sel_q;
                            end
                            y_q <= w_y_inc;
                            x_q <= '0;
                        end
                    end
                end

                default: begin
                    state_q <= S_WAIT;
                end
            endcase
        end
    end

    assign o_data      = data_out_q;
    assign o_data_vld  = vld_q;
    assign o_sof       = sof_q;
    assign o_eol       = eol_q;
    assign o_eof       = eof_q;
    assign o_buf_sel   = buf_sel_q;
    assign o_frame_act = frame_act_q;
    assign o_line_err  = line_err_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ova_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ova_capture
// Description : Directed self-checking bench for ova_capture. Instance A is
//               2 bytes/pixel active-high vsync; instance B is 1 byte/pixel
//               active-low vsync sharing the same data/href stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ova_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data;
    logic        href;
    logic        vsync;
    logic        vsync_b;
    logic        cap_en;
    logic [11:0] x0, x1, y0, y1;
    logic [11:0] b_x0, b_x1, b_y0, b_y1;

    logic [15:0] a_data, b_data, a_fcnt, b_fcnt;
    logic        a_vld, a_sof, a_eol, a_eof, a_buf, a_act, a_err;
    logic        b_vld, b_sof, b_eol, b_eof, b_buf, b_act, b_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign vsync_b = ~vsync;

    ova_capture #(.PIX_BYTES(2), .BYTE_SWAP(0), .LINE_PIX(640), .VSYNC_POL(1), .CNT_W(12)) dut_a (
        .i_pclk(clk), .rst_n(rst_n), .i_data(data), .href(href), .vsync(vsync),
        .i_cap_en(cap_en), .i_x0(x0), .i_x1(x1), .i_y0(y0), .i_y1(y1),
        .o_data(a_data), .o_data_vld(a_vld), .o_sof(a_sof), .o_eol(a_eol), .o_eof(a_eof),
        .o_buf_sel(a_buf), .o_frame_act(a_act), .o_line_err(a_err), .o_frame_cnt(a_fcnt)
    );

    ova_capture #(.PIX_BYTES(1), .BYTE_SWAP(0), .LINE_PIX(640), .VSYNC_POL(0), .CNT_W(12)) dut_b (
        .i_pclk(clk), .rst_n(rst_n), .i_data(data), .href(href), .vsync(vsync_b),
        .i_cap_en(cap_en), .i_x0(b_x0), .i_x1(b_x1), .i_y0(b_y0), .i_y1(b_y1),
        .o_data(b_data), .o_data_vld(b_vld), .o_sof(b_sof), .o_eol(b_eol), .o_eof(b_eof),
        .o_buf_sel(b_buf), .o_frame_act(b_act), .o_line_err(b_err), .o_frame_cnt(b_fcnt)
    );

    // ---------------------------------------------------------- monitors
    int          a_vld_n = 0, a_sof_n = 0, a_eol_n = 0, a_eof_n = 0, a_tog_n = 0, a_clash_n = 0;
    logic [15:0] a_sof_data = 16'h0, a_eol_data = 16'h0;
    logic        a_buf_prev = 1'b0;
    int          b_vld_n = 0, b_sof_n = 0, b_eof_n = 0;
    logic [15:0] b_sof_data = 16'h0, b_last_data = 16'h0;

    always @(negedge clk) begin
        if (a_vld) begin
            a_vld_n++;
            if (a_sof) begin a_sof_n++; a_sof_data = a_data; end
            if (a_eol) begin a_eol_n++; a_eol_data = a_data; end
            if (a_eof) a_clash_n++;
        end
        if (a_eof) a_eof_n++;
        if (a_buf !== a_buf_prev) a_tog_n++;
        a_buf_prev = a_buf;
        if (b_vld) begin
            b_vld_n++;
            b_last_data = b_data;
            if (b_sof) begin b_sof_n++; b_sof_data = b_data; end
        end
        if (b_eof) b_eof_n++;
    end

    // ------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data = b;
        href = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        href = 1'b0;
        repeat (n) tick();
    endtask

    // Pixel word {y[3:0], x[11:0]} sent high byte first; optional 0xABCD
    // first pixel and an optional dangling byte at the end of the line.
    task automatic send_line(input int y, input int npix, input bit special, input bit extra);
        logic [15:0] w;
        logic [3:0]  yy;
        logic [11:0] xx;
        yy = y[3:0];
        for (int x = 0; x < npix; x++) begin
            xx = x[11:0];
            w  = (special && x == 0) ? 16'hABCD : {yy, xx};
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        if (extra) send_byte(8'hEE);
        idle(8);
    endtask

    task automatic vs_pulse(input bit en);
        cap_en = en;
        idle(6);
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        idle(6);
    endtask

    // ---------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if (a_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", a_data); end
        checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", a_vld); end
        checks++; if ({a_sof, a_eol, a_eof} !== 3'b000) begin failures++; $display("FAIL reset_markers got=%b exp=000", {a_sof, a_eol, a_eof}); end
        checks++; if ({a_buf, a_act, a_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {a_buf, a_act, a_err}); end
        checks++; if (a_fcnt !== 16'h0) begin failures++; $display("FAIL reset_fcnt got=%0d exp=0", a_fcnt); end
    endtask

    task automatic test_full_frame();
        int s_vld, s_sof, s_eol, s_eof, s_tog;
        x0 = 12'd0; x1 = 12'd639; y0 = 12'd0; y1 = 12'd3;
        vs_pulse(1'b1);
        checks++; if (a_act !== 1'b1) begin failures++; $display("FAIL full_act got=%b exp=1", a_act); end
        s_vld = a_vld_n; s_sof = a_sof_n; s_eol = a_eol_n; s_eof = a_eof_n; s_tog = a_tog_n;
        for (int y = 0; y < 4; y++) send_line(y, 640, (y == 0), 1'b0);
        vs_pulse(1'b0);
        checks++; if (a_vld_n - s_vld !== 2560) begin failures++; $display("FAIL full_vld got=%0d exp=2560", a_vld_n - s_vld); end
        checks++; if (a_sof_n - s_sof !== 1) begin failures++; $display("FAIL full_sof_cnt got=%0d exp=1", a_sof_n - s_sof); end
        checks++; if (a_sof_data !== 16'hABCD) begin failures++; $display("FAIL full_sof_data got=%h exp=abcd", a_sof_data); end
        checks++; if (a_eol_n - s_eol !== 4) begin failures++; $display("FAIL full_eol_cnt got=%0d exp=4", a_eol_n - s_eol); end
        checks++; if (a_eol_data !== 16'h327F) begin failures++; $display("FAIL full_eol_data got=%h exp=327f", a_eol_data); end
        checks++; if (a_tog_n - s_tog !== 4) begin failures++; $display("FAIL full_buf_tog got=%0d exp=4", a_tog_n - s_tog); end
        checks++; if (a_eof_n - s_eof !== 1) begin failures++; $display("FAIL full_eof got=%0d exp=1", a_eof_n - s_eof); end
        checks++; if (a_fcnt !== 16'd1) begin failures++; $display("FAIL full_fcnt got=%0d exp=1", a_fcnt); end
        checks++; if ({a_act, a_err} !== 2'b00) begin failures++; $display("FAIL full_act_err got=%b exp=00", {a_act, a_err}); end
    endtask

    task automatic test_crop();
        int s_vld, s_sof, s_eol, s_eof, s_tog;
        x0 = 12'd10; x1 = 12'd19; y0 = 12'd1; y1 = 12'd2;
        vs_pulse(1'b1);
        s_vld = a_vld_n; s_sof = a_sof_n; s_eol = a_eol_n; s_eof = a_eof_n; s_tog = a_tog_n;
        for (int y = 0; y < 4; y++) send_line(y, 640, 1'b0, 1'b0);
        vs_pulse(1'b0);
        checks++; if (a_vld_n - s_vld !== 20) begin failures++; $display("FAIL crop_vld got=%0d exp=20", a_vld_n - s_vld); end
        checks++; if (a_sof_n - s_sof !== 1) begin failures++; $display("FAIL crop_sof_cnt got=%0d exp=1", a_sof_n - s_sof); end
        checks++; if (a_sof_data !== 16'h100A) begin failures++; $display("FAIL crop_sof_data got=%h exp=100a", a_sof_data); end
        checks++; if (a_eol_n - s_eol !== 2) begin failures++; $display("FAIL crop_eol_cnt got=%0d exp=2", a_eol_n - s_eol); end
        checks++; if (a_eol_data !== 16'h2013) begin failures++; $display("FAIL crop_eol_data got=%h exp=2013", a_eol_data); end
        checks++; if (a_tog_n - s_tog !== 2) begin failures++; $display("FAIL crop_buf_tog got=%0d exp=2", a_tog_n - s_tog); end
        checks++; if (a_eof_n - s_eof !== 1) begin failures++; $display("FAIL crop_eof got=%0d exp=1", a_eof_n - s_eof); end
        checks++; if (a_fcnt !== 16'd2) begin failures++; $display("FAIL crop_fcnt got=%0d exp=2", a_fcnt); end
    endtask

    task automatic test_line_err();
        int s_vld, s_eol;
        x0 = 12'd0; x1 = 12'd639; y0 = 12'd0; y1 = 12'd3;
        vs_pulse(1'b1);
        s_vld = a_vld_n; s_eol = a_eol_n;
        send_line(0, 639, 1'b0, 1'b0);
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL err_short_line got=%b exp=1", a_err); end
        send_line(1, 640, 1'b0, 1'b1);
        checks++; if (a_vld_n - s_vld !== 1279) begin failures++; $display("FAIL err_vld got=%0d exp=1279", a_vld_n - s_vld); end
        checks++; if (a_eol_n - s_eol !== 1) begin failures++; $display("FAIL err_eol got=%0d exp=1", a_eol_n - s_eol); end
        vs_pulse(1'b1);
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", a_err); end
        checks++; if (a_fcnt !== 16'd3) begin failures++; $display("FAIL err_fcnt got=%0d exp=3", a_fcnt); end
        s_vld = a_vld_n;
        send_line(0, 640, 1'b0, 1'b1);
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL err_odd_byte got=%b exp=1", a_err); end
        checks++; if (a_vld_n - s_vld !== 640) begin failures++; $display("FAIL err_partial_vld got=%0d exp=640", a_vld_n - s_vld); end
        vs_pulse(1'b0);
    endtask

    task automatic test_cap_en();
        int s_vld, s_eof;
        s_vld = a_vld_n; s_eof = a_eof_n;
        vs_pulse(1'b0);
        checks++; if (a_act !== 1'b0) begin failures++; $display("FAIL capen_act_off got=%b exp=0", a_act); end
        send_line(0, 640, 1'b0, 1'b0);
        send_line(1, 640, 1'b0, 1'b0);
        vs_pulse(1'b1);
        checks++; if (a_vld_n - s_vld !== 0) begin failures++; $display("FAIL capen_vld_off got=%0d exp=0", a_vld_n - s_vld); end
        checks++; if (a_eof_n - s_eof !== 0) begin failures++; $display("FAIL capen_eof_off got=%0d exp=0", a_eof_n - s_eof); end
        s_vld = a_vld_n; s_eof = a_eof_n;
        send_line(0, 640, 1'b0, 1'b0);
        send_line(1, 640, 1'b0, 1'b0);
        vs_pulse(1'b0);
        checks++; if (a_vld_n - s_vld !== 1280) begin failures++; $display("FAIL capen_vld_on got=%0d exp=1280", a_vld_n - s_vld); end
        checks++; if (a_eof_n - s_eof !== 1) begin failures++; $display("FAIL capen_eof_on got=%0d exp=1", a_eof_n - s_eof); end
        checks++; if (a_fcnt !== 16'd5) begin failures++; $display("FAIL capen_fcnt got=%0d exp=5", a_fcnt); end
    endtask

    task automatic test_reset_mid();
        int s_vld, s_eof, s_sof;
        y1 = 12'd1;
        vs_pulse(1'b1);
        for (int x = 0; x < 100; x++) begin
            send_byte(8'h12);
            send_byte(x[7:0]);
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({a_vld, a_act, a_buf, a_err} !== 4'b0000) begin failures++; $display("FAIL rstmid_flags got=%b exp=0000", {a_vld, a_act, a_buf, a_err}); end
        checks++; if (a_fcnt !== 16'd0) begin failures++; $display("FAIL rstmid_fcnt got=%0d exp=0", a_fcnt); end
        send_byte(8'h34);
        idle(3);
        rst_n = 1'b1;
        s_vld = a_vld_n;
        send_line(0, 640, 1'b0, 1'b0);
        send_line(1, 640, 1'b0, 1'b0);
        checks++; if (a_vld_n - s_vld !== 0) begin failures++; $display("FAIL rstmid_no_out got=%0d exp=0", a_vld_n - s_vld); end
        checks++; if (a_act !== 1'b0) begin failures++; $display("FAIL rstmid_act got=%b exp=0", a_act); end
        vs_pulse(1'b1);
        s_vld = a_vld_n; s_eof = a_eof_n; s_sof = a_sof_n;
        send_line(0, 640, 1'b0, 1'b0);
        send_line(1, 640, 1'b0, 1'b0);
        vs_pulse(1'b0);
        checks++; if (a_vld_n - s_vld !== 1280) begin failures++; $display("FAIL rstmid_vld got=%0d exp=1280", a_vld_n - s_vld); end
        checks++; if (a_sof_n - s_sof !== 1) begin failures++; $display("FAIL rstmid_sof got=%0d exp=1", a_sof_n - s_sof); end
        checks++; if (a_eof_n - s_eof !== 1) begin failures++; $display("FAIL rstmid_eof got=%0d exp=1", a_eof_n - s_eof); end
        checks++; if (a_fcnt !== 16'd1) begin failures++; $display("FAIL rstmid_fcnt got=%0d exp=1", a_fcnt); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", a_err); end
    endtask

    task automatic test_pol_pix1();
        int s_vld, s_sof, s_eof;
        vs_pulse(1'b1);
        checks++; if (b_act !== 1'b1) begin failures++; $display("FAIL b_act got=%b exp=1", b_act); end
        s_vld = b_vld_n; s_sof = b_sof_n; s_eof = b_eof_n;
        send_byte(8'h5A);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(8);
        vs_pulse(1'b0);
        checks++; if (b_vld_n - s_vld !== 3) begin failures++; $display("FAIL b_vld got=%0d exp=3", b_vld_n - s_vld); end
        checks++; if (b_sof_n - s_sof !== 1) begin failures++; $display("FAIL b_sof_cnt got=%0d exp=1", b_sof_n - s_sof); end
        checks++; if (b_sof_data !== 16'h005A) begin failures++; $display("FAIL b_sof_data got=%h exp=005a", b_sof_data); end
        checks++; if (b_last_data !== 16'h0022) begin failures++; $display("FAIL b_last_data got=%h exp=0022", b_last_data); end
        checks++; if (b_eof_n - s_eof !== 1) begin failures++; $display("FAIL b_eof got=%0d exp=1", b_eof_n - s_eof); end
        checks++; if (b_act !== 1'b0) begin failures++; $display("FAIL b_act_end got=%b exp=0", b_act); end
    endtask

    task automatic test_no_clash();
        checks++; if (a_clash_n !== 0) begin failures++; $display("FAIL eof_with_vld got=%0d exp=0", a_clash_n); end
    endtask

    initial begin
        rst_n  = 1'b0;
        data   = 8'h00;
        href   = 1'b0;
        vsync  = 1'b0;
        cap_en = 1'b1;
        x0 = 12'd0; x1 = 12'd639; y0 = 12'd0; y1 = 12'd3;
        b_x0 = 12'd0; b_x1 = 12'hFFF; b_y0 = 12'd0; b_y1 = 12'hFFF;

        test_reset();
        test_full_frame();
        test_crop();
        test_line_err();
        test_cap_en();
        test_reset_mid();
        test_pol_pix1();
        test_no_clash();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
